// File: rtl/tick_wdt.sv
// Watchdog timer that counts edges of the slow divider toggle and flags expiry
// once the elapsed tick count reaches the timeout latched at arm time.
module tick_wdt #(
  parameter int CNT_W      = 8,
  parameter int BOTH_EDGES = 1
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iDivClk,
  input  logic             iEn,
  input  logic             iKick,
  input  logic             iClear,
  input  logic [CNT_W-1:0] iTimeout,
  output logic             oRunning,
  output logic             oExpired,
  output logic             oTimeoutPulse,
  output logic [CNT_W-1:0] oCount
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t           state_q;
  logic             divClkPrev_q;
  logic [CNT_W-1:0] limit_q;
  logic [CNT_W-1:0] count_q;
  logic             running_q;
  logic             expired_q;
  logic             pulse_q;
  logic             tick;
  logic [CNT_W-1:0] countInc;

  // iDivClk is already in the iClk domain, so edges are detected without a synchronizer.
  always_comb begin
    if (BOTH_EDGES != 0) begin
      tick = iDivClk ^ divClkPrev_q;
    end else begin
      tick = iDivClk & ~divClkPrev_q;
    end
    countInc = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q      <= IDLE;
      divClkPrev_q <= 1'b0;
      limit_q      <= '0;
      count_q      <= '0;
      running_q    <= 1'b0;
      expired_q    <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      divClkPrev_q <= iDivClk;
      pulse_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          count_q <= '0;
          if (iEn) begin
            limit_q <= iTimeout;
            if (iTimeout != '0) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end else begin
              state_q   <= EXPIRED;
              expired_q <= 1'b1;
              pulse_q   <= 1'b1;
            end
          end
        end

        // Abort beats kick, and kick beats a same-cycle tick.
        RUN: begin
          if (!iEn) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            count_q   <= '0;
          end else if (iKick) begin
            count_q <= '0;
          end else if (tick) begin
            if (countInc == limit_q) begin
              state_q   <= EXPIRED;
              running_q <= 1'b0;
              expired_q <= 1'b1;
              pulse_q   <= 1'b1;
              count_q   <= limit_q;
            end else begin
              count_q <= countInc;
            end
          end
        end

        EXPIRED: begin
          if (iClear) begin
            state_q   <= IDLE;
            expired_q <= 1'b0;
            count_q   <= '0;
          end
        end

        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
          expired_q <= 1'b0;
          count_q   <= '0;
        end
      endcase
    end
  end

  assign oRunning      = running_q;
  assign oExpired      = expired_q;
  assign oTimeoutPulse = pulse_q;
  assign oCount        = count_q;

endmodule
